lsu_wb: RTL and testbench
=========================

# lsu_wb

Load/store unit for the single-issue RV32I core. It accepts one memory request at a time from execute and drives a word-wide valid/ready data bus. Store data is replicated with byte strobes. Load data is aligned and sign/zero-extended. Each completed load issues exactly one write pulse that drives the register file's write port (a3/wd3/we3) directly.

## Interface
- `TIMEOUT_CYCLES`, default 255: max cycles `mem_valid` is held without `mem_ready`; 0 disables the timeout.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle, request accepted when `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign encoding (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data (rs2).
- `req_rd`  in  5  load destination register.
- `mem_valid`  out  1  bus request.
- `mem_ready`  in  1  bus completion.
- `mem_addr`  out  32  word address, bits [1:0] always 0.
- `mem_we`  out  1  bus write.
- `mem_wstrb`  out  4  byte enables; 0000 for loads.
- `mem_wdata`  out  32  replicated store data.
- `mem_rdata`  in  32  load data, valid when `mem_valid & mem_ready`.
- `wb_we`  out  1  regfile write enable.
- `wb_rd`  out  5  regfile write address.
- `wb_data`  out  32  regfile write data.
- `busy`  out  1  state != IDLE.
- `err`  out  1  one-cycle pulse on illegal funct3, misalignment (if enabled), or bus timeout.

## Operation
- FSM states: IDLE, BUS, WB. Reset enters IDLE.
- **IDLE**
  - `req_ready`=1.
  - On accept, latch addr/funct3/rd/we/wdata.
  - Legal request: go to BUS.
  - Illegal funct3 (011, 11x; or store with funct3[2]=1): `err` pulses next cycle, no bus activity, stay in IDLE.
- **BUS**
  - `mem_valid`=1; bus outputs are stable until `mem_ready`.
  - On `mem_ready`, a store goes to IDLE.
  - On `mem_ready`, a load captures extracted data and goes to WB.
- **WB**
  - `wb_we`=1 for exactly one cycle with `wb_rd`/`wb_data`, then IDLE.
  - `wb_we` is forced to 0 when rd=0; the WB cycle still elapses.
- **Store data**
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{byte}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW: wstrb = 1111.
- **Load extract**
  - Shift `mem_rdata` right by 8*addr[1:0].
  - Byte/half are sign-extended for LB/LH and zero-extended for LBU/LHU.
- **Timeout**
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering BUS and increments each BUS cycle without `mem_ready`.
  - After TIMEOUT_CYCLES such cycles, `mem_valid` drops, `err` pulses one cycle, the FSM returns to IDLE, and no writeback occurs.
  - `mem_ready` arriving in the same cycle the limit is reached wins: the access completes normally.
- `mem_ready` while not in BUS is ignored.

## Timing
- Reset values:
  - `req_ready`=1 (IDLE); requests during reset are ignored.
  - All other outputs 0, including bus data/addr/strb and `wb_*`.
- Reset mid-operation: `mem_valid`, `wb_we` and `busy` drop asynchronously; a pending load is discarded.
- Load, zero-wait bus:
  - Accept at edge 0, `mem_valid` cycle 1.
  - `mem_ready` sampled at edge 1, `wb_we` cycle 2.
  - `req_ready` again cycle 3.
- Store, zero-wait bus: accept edge 0, `mem_valid` cycle 1, `req_ready` cycle 2.
- Each bus wait cycle adds one cycle to either latency.
- `wb_*` are registered and held for the full cycle, so the regfile's falling-edge write sees stable data.
- At most one outstanding request.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned requests do not reach the bus: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - `err` pulses the cycle after accept; the FSM stays in IDLE and no writeback occurs.
- Undefined:
  - Offending low address bits are cleared (halfword: addr[0]; word: addr[1:0]) and the access proceeds silently.
  - `err` is never raised for alignment.

## Test plan
- LB from 0x1003 with `mem_rdata`=0x80FF_FF00, zero-wait -> `mem_addr`=0x1000, cycle 2 `wb_we`=1, `wb_data`=0xFFFF_FF80, `wb_rd`=latched rd.
- LHU from 0x2002, `mem_rdata`=0x8001_1234 -> `wb_data`=0x0000_8001; same access as LH -> 0xFFFF_8001.
- SB 0xAB to 0x3001 with 2 bus wait cycles -> `mem_wstrb`=0010, `mem_wdata`=0xABAB_ABAB, stable 3 cycles; `req_ready` returns 1 cycle after `mem_ready`; `wb_we` never asserts.
- LW with rd=0 -> bus access completes, `wb_we` stays 0, `req_ready` is 1 in cycle 3.
- TIMEOUT_CYCLES=4, `mem_ready` held 0 -> `mem_valid` high exactly 4 cycles, then `err` pulse, no `wb_we`. Reset asserted in BUS of a second load -> `mem_valid`=0 immediately, `req_ready`=1.
- LW to 0x4002: with `LSU_MISALIGN_TRAP_EN` -> `err` pulse, `mem_valid` never asserts; without it -> `mem_addr`=0x4000, normal writeback. funct3=011 -> `err` in both builds.

Source files
------------

// File: rtl/lsu_wb.sv
// lsu_wb: single-outstanding RV32I load/store unit with a registered regfile writeback port.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with err instead of masking low address bits.
module lsu_wb #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state   // 0 IDLE, 1 BUS, 2 WB
);
  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
  // mem_valid and its addr/we/wstrb/wdata hold steady from assertion until that edge.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [29:0]   waddr_q, waddr_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [4:0]    rd_q, rd_d;
  logic          we_q, we_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          wb_we_q, wb_we_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic          req_illegal;
  logic          req_reject;
  logic [1:0]    req_off;
  logic [31:0]   rdata_sh;
  logic [31:0]   load_val;

  // Request decode: legality and the effective byte offset inside the word.
  always_comb begin
    req_illegal = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                         : ((req_funct3[1:0] == 2'b11) | (req_funct3[2] & req_funct3[1]));
`ifdef LSU_MISALIGN_TRAP_EN
    req_reject = req_illegal
               | ((req_funct3[1:0] == 2'b01) & req_addr[0])
               | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
`else
    req_reject = req_illegal;
`endif
    case (req_funct3[1:0])
      2'b00:   req_off = req_addr[1:0];
      2'b01:   req_off = {req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

  always_comb begin
    rdata_sh = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b001:  load_val = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b100:  load_val = {24'h0, rdata_sh[7:0]};
      3'b101:  load_val = {16'h0, rdata_sh[15:0]};
      default: load_val = rdata_sh;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    off_d     = off_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    we_d      = we_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    wb_we_d   = 1'b0;
    wb_data_d = wb_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          waddr_d  = req_addr[31:2];
          off_d    = req_off;
          funct3_d = req_funct3;
          rd_d     = req_rd;
          we_d     = req_we;
          wstrb_d  = 4'b0000;
          wdata_d  = 32'h0;
          if (req_we) begin
            case (req_funct3[1:0])
              2'b00: begin
                wstrb_d = 4'b0001 << req_off;
                wdata_d = {4{req_wdata[7:0]}};
              end
              2'b01: begin
                wstrb_d = req_off[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata[15:0]}};
              end
              default: begin
                wstrb_d = 4'b1111;
                wdata_d = req_wdata;
              end
            endcase
          end
          if (req_reject) begin
            err_d = 1'b1;
          end else begin
            state_d = BUS;
            cnt_d   = '0;
          end
        end
      end
      BUS: begin
        // A completion in the limit cycle beats the timeout.
        if (mem_ready) begin
          if (we_q) begin
            state_d = IDLE;
          end else begin
            state_d   = WB;
            wb_data_d = load_val;
            wb_we_d   = (rd_q != 5'd0);
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      waddr_q   <= '0;
      off_q     <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      off_q     <= off_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wb_we_q   <= wb_we_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_valid = (state_q == BUS);
  assign mem_addr  = {waddr_q, 2'b00};
  assign mem_we    = mem_valid & we_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb: directed scenarios plus randomized accesses against a byte-level model.
module tb_lsu_wb;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy, err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  lsu_wb #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  typedef struct {
    int          valid_cycles;
    bit          unstable;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
    int          wb_cnt;
    int          wb_cycle;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    int          err_cnt;
    int          err_cycle;
    int          ready_cycle;
  } obs_t;

  // Reference model: access size in bytes, byte offset after masking, extension by arithmetic.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
    int o = int'(a[1:0]);
    return o - (o % m_size(f3));
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    int     nbits = 8 * m_size(f3);
    longint v     = longint'(rdata >> (8 * m_off(f3, a)));
    if (nbits < 32) begin
      v = v % (64'sd1 << nbits);
      if (!f3[2] && v >= (64'sd1 << (nbits - 1))) v = v - (64'sd1 << nbits);
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    return 4'(((1 << m_size(f3)) - 1) << m_off(f3, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int s = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % s) +: 8];
    return r;
  endfunction

  // Driver: issue one request, act as a bus slave with 'waits' wait cycles, record what the DUT did.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                            input int waits, output obs_t o);
    o.valid_cycles = 0; o.unstable = 1'b0; o.addr = '0; o.wdata = '0; o.wstrb = '0; o.we = 1'b0;
    o.wb_cnt = 0; o.wb_cycle = 0; o.wb_data = '0; o.wb_rd = '0;
    o.err_cnt = 0; o.err_cycle = 0; o.ready_cycle = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (mem_valid === 1'b1) begin
        if (o.valid_cycles == 0) begin
          o.addr = mem_addr; o.we = mem_we; o.wstrb = mem_wstrb; o.wdata = mem_wdata;
        end else if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== {o.addr, o.we, o.wstrb, o.wdata}) begin
          o.unstable = 1'b1;
        end
        o.valid_cycles++;
        mem_ready = (o.valid_cycles > waits);
        mem_rdata = mem_ready ? rdata : $urandom;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (wb_we === 1'b1) begin
        o.wb_cnt++; o.wb_cycle = cyc; o.wb_data = wb_data; o.wb_rd = wb_rd;
      end
      if (err === 1'b1) begin
        o.err_cnt++; o.err_cycle = cyc;
      end
      if (req_ready === 1'b1) begin
        o.ready_cycle = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1234;
    req_wdata = $urandom; req_rd = 5'd3; mem_ready = 1'b1; mem_rdata = $urandom;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_checks++; if ({mem_valid, busy, err, wb_we} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {mem_valid, busy, err, wb_we}); end
    n_checks++; if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== 69'h0) begin n_fail++; $display("FAIL rst_bus: got addr %h we %b strb %b wdata %h want all 0", mem_addr, mem_we, mem_wstrb, mem_wdata); end
    n_checks++; if ({wb_rd, wb_data} !== 37'h0) begin n_fail++; $display("FAIL rst_wb: got rd %0d data %h want 0", wb_rd, wb_data); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_dbg_state: got %0d want 0", dbg_state); end
    reset = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({busy, mem_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_no_accept: got busy %b valid %b want 0 0", busy, mem_valid); end
  endtask

  task automatic test_load_sign();
    obs_t o;
    run_access(1'b0, 3'b000, 32'h1003, $urandom, 5'd9, 32'h80FF_FF00, 0, o);
    n_checks++; if (o.addr !== 32'h1000) begin n_fail++; $display("FAIL lb_addr: got %h want 00001000", o.addr); end
    n_checks++; if ({o.we, o.wstrb} !== 5'b0) begin n_fail++; $display("FAIL lb_we_strb: got %b %b want 0 0000", o.we, o.wstrb); end
    n_checks++; if ({o.wb_cnt, o.wb_cycle} !== {32'd1, 32'd2}) begin n_fail++; $display("FAIL lb_wb_timing: got %0d pulses at cycle %0d want 1 at 2", o.wb_cnt, o.wb_cycle); end
    n_checks++; if (o.wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_wb_data: got %h want ffffff80", o.wb_data); end
    n_checks++; if (o.wb_rd !== 5'd9) begin n_fail++; $display("FAIL lb_wb_rd: got %0d want 9", o.wb_rd); end
    n_checks++; if (o.ready_cycle !== 3) begin n_fail++; $display("FAIL lb_ready_cycle: got %0d want 3", o.ready_cycle); end
  endtask

  task automatic test_load_half();
    obs_t o;
    run_access(1'b0, 3'b101, 32'h2002, $urandom, 5'd12, 32'h8001_1234, 0, o);
    n_checks++; if (o.wb_data !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_data: got %h want 00008001", o.wb_data); end
    run_access(1'b0, 3'b001, 32'h2002, $urandom, 5'd12, 32'h8001_1234, 1, o);
    n_checks++; if (o.wb_data !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_data: got %h want ffff8001", o.wb_data); end
    n_checks++; if (o.ready_cycle !== 4) begin n_fail++; $display("FAIL lh_wait_ready: got %0d want 4", o.ready_cycle); end
  endtask

  task automatic test_store_wait();
    obs_t o;
    run_access(1'b1, 3'b000, 32'h3001, 32'h1234_56AB, 5'd5, $urandom, 2, o);
    n_checks++; if (o.wstrb !== 4'b0010) begin n_fail++; $display("FAIL sb_strb: got %b want 0010", o.wstrb); end
    n_checks++; if (o.wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata: got %h want abababab", o.wdata); end
    n_checks++; if ({o.we, o.addr} !== {1'b1, 32'h3000}) begin n_fail++; $display("FAIL sb_we_addr: got %b %h want 1 00003000", o.we, o.addr); end
    n_checks++; if (o.valid_cycles !== 3 || o.unstable) begin n_fail++; $display("FAIL sb_hold: got %0d cycles unstable %b want 3 stable", o.valid_cycles, o.unstable); end
    n_checks++; if (o.ready_cycle !== 4) begin n_fail++; $display("FAIL sb_ready_cycle: got %0d want 4", o.ready_cycle); end
    n_checks++; if (o.wb_cnt !== 0) begin n_fail++; $display("FAIL sb_no_wb: got %0d pulses want 0", o.wb_cnt); end
  endtask

  task automatic test_rd_zero();
    obs_t o;
    run_access(1'b0, 3'b010, 32'h6000, $urandom, 5'd0, 32'hDEAD_BEEF, 0, o);
    n_checks++; if (o.valid_cycles !== 1) begin n_fail++; $display("FAIL rd0_bus: got %0d cycles want 1", o.valid_cycles); end
    n_checks++; if (o.wb_cnt !== 0) begin n_fail++; $display("FAIL rd0_no_wb: got %0d pulses want 0", o.wb_cnt); end
    n_checks++; if (o.ready_cycle !== 3) begin n_fail++; $display("FAIL rd0_ready_cycle: got %0d want 3", o.ready_cycle); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1'b0, 3'b010, 32'h7000, $urandom, 5'd4, $urandom, 100, o);
    n_checks++; if (o.valid_cycles !== TO) begin n_fail++; $display("FAIL to_valid_cycles: got %0d want %0d", o.valid_cycles, TO); end
    n_checks++; if ({o.err_cnt, o.err_cycle} !== {32'd1, 32'(TO + 1)}) begin n_fail++; $display("FAIL to_err: got %0d pulses at %0d want 1 at %0d", o.err_cnt, o.err_cycle, TO + 1); end
    n_checks++; if (o.wb_cnt !== 0) begin n_fail++; $display("FAIL to_no_wb: got %0d want 0", o.wb_cnt); end
    n_checks++; if (o.ready_cycle !== TO + 1) begin n_fail++; $display("FAIL to_ready_cycle: got %0d want %0d", o.ready_cycle, TO + 1); end
    run_access(1'b0, 3'b010, 32'h7100, $urandom, 5'd4, 32'hCAFE_F00D, TO - 1, o);
    n_checks++; if ({o.err_cnt, o.wb_cnt} !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL to_edge_complete: got err %0d wb %0d want 0 1", o.err_cnt, o.wb_cnt); end
    n_checks++; if (o.wb_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL to_edge_data: got %h want cafef00d", o.wb_data); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   seen = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h5000; req_rd = 5'd7;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL rm_in_bus: got %b want 1", mem_valid); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({mem_valid, busy, wb_we, req_ready} !== 4'b0001) begin n_fail++; $display("FAIL rm_async_drop: got valid %b busy %b wb_we %b ready %b want 0 0 0 1", mem_valid, busy, wb_we, req_ready); end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1; mem_rdata = $urandom;
    repeat (4) begin
      @(posedge clk); #1;
      if (wb_we !== 1'b0 || mem_valid !== 1'b0) seen++;
    end
    mem_ready = 1'b0;
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rm_discarded: got %0d active cycles want 0", seen); end
    run_access(1'b0, 3'b010, 32'h5004, $urandom, 5'd7, 32'h0BAD_F00D, 0, o);
    n_checks++; if ({o.wb_cnt, o.wb_data} !== {32'd1, 32'h0BAD_F00D}) begin n_fail++; $display("FAIL rm_recover: got %0d pulses data %h want 1 0badf00d", o.wb_cnt, o.wb_data); end
  endtask

  task automatic test_misalign();
    obs_t o;
    run_access(1'b0, 3'b010, 32'h4002, $urandom, 5'd3, 32'h1357_9BDF, 0, o);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if ({o.err_cnt, o.err_cycle} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL ma_lw_err: got %0d pulses at %0d want 1 at 1", o.err_cnt, o.err_cycle); end
    n_checks++; if ({o.valid_cycles, o.wb_cnt} !== 64'd0) begin n_fail++; $display("FAIL ma_lw_quiet: got valid %0d wb %0d want 0 0", o.valid_cycles, o.wb_cnt); end
`else
    n_checks++; if (o.addr !== 32'h4000) begin n_fail++; $display("FAIL ma_lw_addr: got %h want 00004000", o.addr); end
    n_checks++; if ({o.err_cnt, o.wb_cnt} !== {32'd0, 32'd1} || o.wb_data !== 32'h1357_9BDF) begin n_fail++; $display("FAIL ma_lw_wb: got err %0d wb %0d data %h want 0 1 13579bdf", o.err_cnt, o.wb_cnt, o.wb_data); end
    run_access(1'b1, 3'b001, 32'h7003, 32'h0000_BEEF, 5'd1, $urandom, 0, o);
    n_checks++; if ({o.wstrb, o.wdata, 32'(o.err_cnt)} !== {4'b1100, 32'hBEEF_BEEF, 32'd0}) begin n_fail++; $display("FAIL ma_sh: got strb %b wdata %h err %0d want 1100 beefbeef 0", o.wstrb, o.wdata, o.err_cnt); end
`endif
    run_access(1'b0, 3'b011, 32'h4000, $urandom, 5'd3, $urandom, 0, o);
    n_checks++; if ({o.err_cnt, o.valid_cycles, o.ready_cycle} !== {32'd1, 32'd0, 32'd1}) begin n_fail++; $display("FAIL ill_f3_011: got err %0d valid %0d ready at %0d want 1 0 1", o.err_cnt, o.valid_cycles, o.ready_cycle); end
    run_access(1'b1, 3'b100, 32'h4000, $urandom, 5'd3, $urandom, 0, o);
    n_checks++; if ({o.err_cnt, o.valid_cycles} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL ill_store_f3: got err %0d valid %0d want 1 0", o.err_cnt, o.valid_cycles); end
  endtask

  task automatic test_random();
    obs_t        o;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata, exp;
    logic [4:0]  rd;
    int          waits;
    for (int i = 0; i < 24; i++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      addr  = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      addr  = addr & ~(32'(m_size(f3)) - 32'd1);
`endif
      wd    = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom);
      waits = $urandom_range(0, 2);
      if (!we && rd != 5'd0) exp_q.push_back(m_load(f3, addr, rdata));
      run_access(we, f3, addr, wd, rd, rdata, waits, o);
      n_checks++; if ({o.addr, o.we} !== {addr[31:2], 2'b00, we}) begin n_fail++; $display("FAIL rnd_addr_we[%0d]: got %h %b want %h %b", i, o.addr, o.we, {addr[31:2], 2'b00}, we); end
      n_checks++; if (o.wstrb !== (we ? m_strb(f3, addr) : 4'b0000)) begin n_fail++; $display("FAIL rnd_strb[%0d]: got %b want %b", i, o.wstrb, we ? m_strb(f3, addr) : 4'b0000); end
      if (we) begin
        n_checks++; if (o.wdata !== m_wdata(f3, wd)) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, o.wdata, m_wdata(f3, wd)); end
      end
      n_checks++; if (o.valid_cycles !== waits + 1 || o.unstable || o.err_cnt !== 0) begin n_fail++; $display("FAIL rnd_bus[%0d]: got %0d cycles unstable %b err %0d want %0d stable 0", i, o.valid_cycles, o.unstable, o.err_cnt, waits + 1); end
      n_checks++; if (o.ready_cycle !== (we ? waits + 2 : waits + 3)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0d want %0d", i, o.ready_cycle, we ? waits + 2 : waits + 3); end
      n_checks++; if (o.wb_cnt !== ((!we && rd != 5'd0) ? 1 : 0)) begin n_fail++; $display("FAIL rnd_wb_cnt[%0d]: got %0d", i, o.wb_cnt); end
      if (o.wb_cnt == 1 && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        n_checks++; if ({o.wb_data, o.wb_rd} !== {exp, rd}) begin n_fail++; $display("FAIL rnd_wb[%0d]: got %h rd %0d want %h rd %0d", i, o.wb_data, o.wb_rd, exp, rd); end
      end
    end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rnd_sb_drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; req_rd = '0; mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_load_sign();
    test_load_half();
    test_store_wait();
    test_rd_zero();
    test_timeout();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
